// File: rtl/riscv_core_dpath_commit_rob.sv
// riscv_core_dpath_commit_rob
//   In-order writeback buffer (reorder buffer) for the dual-issue pipeline and the sole
//   driver of the register file write ports. Issue allocates up to two entries per cycle
//   in program order. The two execute pipes complete entries out of order. Up to the two
//   oldest completed entries retire per cycle: the older one on port 0, the younger on port 1.
//
// Ports
//   clk, reset_n                    clock, synchronous active-low reset
//   alloc{0,1}_val/_wen/_waddr      allocation requests (alloc1 only counts with alloc0)
//   alloc_rdy                       at least two free entries
//   alloc{0,1}_slot                 slot ids handed to the two allocations (tail, tail+1)
//   fill{0,1}_val/_slot/_wdata      result completion from execute pipes A/B
//   wen{0,1}_p/waddr{0,1}_p/wdata{0,1}_p  register file write ports (port 1 = younger)
//   count                           occupied entries
module riscv_core_dpath_commit_rob #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             alloc0_val,
  input  logic             alloc0_wen,
  input  logic [4:0]       alloc0_waddr,
  input  logic             alloc1_val,
  input  logic             alloc1_wen,
  input  logic [4:0]       alloc1_waddr,
  output logic             alloc_rdy,
  output logic [PTR_W-1:0] alloc0_slot,
  output logic [PTR_W-1:0] alloc1_slot,
  input  logic             fill0_val,
  input  logic [PTR_W-1:0] fill0_slot,
  input  logic [31:0]      fill0_wdata,
  input  logic             fill1_val,
  input  logic [PTR_W-1:0] fill1_slot,
  input  logic [31:0]      fill1_wdata,
  output logic             wen0_p,
  output logic [4:0]       waddr0_p,
  output logic [31:0]      wdata0_p,
  output logic             wen1_p,
  output logic [4:0]       waddr1_p,
  output logic [31:0]      wdata1_p,
  output logic [PTR_W:0]   count
);

  // Highest occupancy that still leaves room for a full pair allocation.
  localparam logic [PTR_W:0] RDY_MAX = (PTR_W + 1)'(DEPTH - 2);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0] head1, tail1;
  logic [PTR_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d, wen_q, wen_d;
  logic [4:0]       waddr_q [DEPTH];
  logic [4:0]       waddr_d [DEPTH];
  logic [31:0]      wdata_q [DEPTH];
  logic [31:0]      wdata_d [DEPTH];

  logic             ret0, ret1;
  logic             alloc0_acc, alloc1_acc;
  logic             fill0_hit, fill1_hit;
  logic [1:0]       nalloc, nret;

  assign head1 = head_q + PTR_W'(1);
  assign tail1 = tail_q + PTR_W'(1);

  // Retire decisions come only from registered state: a fill never bypasses to the ports.
  // An empty buffer has valid[head]=0, so nothing retires.
  assign ret0 = valid_q[head_q] & done_q[head_q];
  assign ret1 = ret0 & valid_q[head1] & done_q[head1];

  assign alloc_rdy  = reset_n & (count_q <= RDY_MAX);
  assign alloc0_acc = alloc_rdy & alloc0_val;
  assign alloc1_acc = alloc0_acc & alloc1_val;

  assign nalloc = {1'b0, alloc0_acc} + {1'b0, alloc1_acc};
  assign nret   = {1'b0, ret0} + {1'b0, ret1};

  // Fills land only on allocated, still-incomplete slots.
  assign fill0_hit = fill0_val & valid_q[fill0_slot] & ~done_q[fill0_slot];
  assign fill1_hit = fill1_val & valid_q[fill1_slot] & ~done_q[fill1_slot];

  assign alloc0_slot = tail_q;
  assign alloc1_slot = tail1;
  assign count       = count_q;

  assign wen0_p   = ret0 & wen_q[head_q] & reset_n;
  assign waddr0_p = waddr_q[head_q];
  assign wdata0_p = wdata_q[head_q];
  assign wen1_p   = ret1 & wen_q[head1] & reset_n;
  assign waddr1_p = waddr_q[head1];
  assign wdata1_p = wdata_q[head1];

  // Per-entry next state. Retire, fill and alloc target disjoint entries
  // (retiring entries are done, fill targets are valid and not done, alloc targets are free),
  // so one priority chain per entry is enough; fill0 ahead of fill1 makes pipe A win a collision.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    wen_d   = wen_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    for (int i = 0; i < DEPTH; i++) begin
      if ((ret0 && (head_q == PTR_W'(i))) || (ret1 && (head1 == PTR_W'(i)))) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end else if (fill0_hit && (fill0_slot == PTR_W'(i))) begin
        done_d[i]  = 1'b1;
        wdata_d[i] = fill0_wdata;
      end else if (fill1_hit && (fill1_slot == PTR_W'(i))) begin
        done_d[i]  = 1'b1;
        wdata_d[i] = fill1_wdata;
      end else if (alloc0_acc && (tail_q == PTR_W'(i))) begin
        valid_d[i] = 1'b1;
        done_d[i]  = 1'b0;
        wen_d[i]   = alloc0_wen;
        waddr_d[i] = alloc0_waddr;
      end else if (alloc1_acc && (tail1 == PTR_W'(i))) begin
        valid_d[i] = 1'b1;
        done_d[i]  = 1'b0;
        wen_d[i]   = alloc1_wen;
        waddr_d[i] = alloc1_waddr;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
    head_d  = head_q + PTR_W'(nret);
    tail_d  = tail_q + PTR_W'(nalloc);
    count_d = count_q + (PTR_W + 1)'(nalloc) - (PTR_W + 1)'(nret);
  end

  // Control state: pointers, occupancy and entry valid/done flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Entry payload; only meaningful while the entry is valid, so it needs no reset.
  always_ff @(posedge clk) begin
    wen_q   <= wen_d;
    waddr_q <= waddr_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_riscv_core_dpath_commit_rob.sv
// Bench for riscv_core_dpath_commit_rob: directed scenarios followed by random traffic,
// all checked against a program-order queue model and a model register file.
module tb_riscv_core_dpath_commit_rob;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n = 1'b0;
  logic        alloc0_val = 1'b0, alloc0_wen = 1'b0, alloc1_val = 1'b0, alloc1_wen = 1'b0;
  logic [4:0]  alloc0_waddr = 5'd0, alloc1_waddr = 5'd0;
  logic        alloc_rdy;
  logic [3:0]  alloc0_slot, alloc1_slot;
  logic        fill0_val = 1'b0, fill1_val = 1'b0;
  logic [3:0]  fill0_slot = 4'd0, fill1_slot = 4'd0;
  logic [31:0] fill0_wdata = 32'd0, fill1_wdata = 32'd0;
  logic        wen0_p, wen1_p;
  logic [4:0]  waddr0_p, waddr1_p;
  logic [31:0] wdata0_p, wdata1_p;
  logic [4:0]  count;

  riscv_core_dpath_commit_rob #(.DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .alloc0_val(alloc0_val), .alloc0_wen(alloc0_wen), .alloc0_waddr(alloc0_waddr),
    .alloc1_val(alloc1_val), .alloc1_wen(alloc1_wen), .alloc1_waddr(alloc1_waddr),
    .alloc_rdy(alloc_rdy), .alloc0_slot(alloc0_slot), .alloc1_slot(alloc1_slot),
    .fill0_val(fill0_val), .fill0_slot(fill0_slot), .fill0_wdata(fill0_wdata),
    .fill1_val(fill1_val), .fill1_slot(fill1_slot), .fill1_wdata(fill1_wdata),
    .wen0_p(wen0_p), .waddr0_p(waddr0_p), .wdata0_p(wdata0_p),
    .wen1_p(wen1_p), .waddr1_p(waddr1_p), .wdata1_p(wdata1_p),
    .count(count)
  );

  // Register file fed by the DUT write ports; port 1 is applied last, x0 discarded.
  logic [31:0] dut_rf [32] = '{default: 32'h0};
  always @(posedge clk) begin
    if (wen0_p && waddr0_p != 5'd0) dut_rf[waddr0_p] <= wdata0_p;
    if (wen1_p && waddr1_p != 5'd0) dut_rf[waddr1_p] <= wdata1_p;
  end

  // Reference model: in-flight instructions in program order.
  typedef struct {
    int          slot;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        done;
  } ent_t;
  ent_t        q[$];
  int          tail_slot = 0;
  logic [31:0] model_rf [32] = '{default: 32'h0};

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus for the next cycle, applied at the following falling edge.
  logic        s_rst_n, s_a0v, s_a0w, s_a1v, s_a1w, s_f0v, s_f1v;
  logic [4:0]  s_a0a, s_a1a;
  logic [3:0]  s_f0s, s_f1s;
  logic [31:0] s_f0d, s_f1d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
  endtask

  task automatic idle();
    s_rst_n = 1'b1; s_a0v = 1'b0; s_a0w = 1'b0; s_a0a = 5'd0; s_a1v = 1'b0; s_a1w = 1'b0;
    s_a1a = 5'd0; s_f0v = 1'b0; s_f0s = 4'd0; s_f0d = 32'd0; s_f1v = 1'b0; s_f1s = 4'd0;
    s_f1d = 32'd0;
  endtask

  task automatic apply_fill(input logic v, input logic [3:0] s, input logic [31:0] d);
    if (v) begin
      foreach (q[i]) begin
        if (q[i].slot == int'(s) && !q[i].done) begin
          q[i].done = 1'b1;
          q[i].data = d;
        end
      end
    end
  endtask

  task automatic push_alloc(input logic w, input logic [4:0] a);
    ent_t e;
    e.slot = tail_slot; e.wen = w; e.waddr = a; e.data = 32'd0; e.done = 1'b0;
    q.push_back(e);
    tail_slot = (tail_slot + 1) % DEPTH;
  endtask

  // One clock: drive stimulus, check outputs against the model, advance the model.
  task automatic run_cycle();
    int   nret;
    logic e_rdy, e_w0, e_w1;
    @(negedge clk);
    reset_n = s_rst_n;
    alloc0_val = s_a0v; alloc0_wen = s_a0w; alloc0_waddr = s_a0a;
    alloc1_val = s_a1v; alloc1_wen = s_a1w; alloc1_waddr = s_a1a;
    fill0_val = s_f0v; fill0_slot = s_f0s; fill0_wdata = s_f0d;
    fill1_val = s_f1v; fill1_slot = s_f1s; fill1_wdata = s_f1d;
    #1;
    e_rdy = s_rst_n && (q.size() <= DEPTH - 2);
    nret = 0;
    if (s_rst_n && q.size() > 0) if (q[0].done) nret = 1;
    if (nret == 1 && q.size() > 1) if (q[1].done) nret = 2;
    e_w0 = 1'b0; e_w1 = 1'b0;
    if (nret >= 1) e_w0 = q[0].wen;
    if (nret == 2) e_w1 = q[1].wen;
    chk("alloc_rdy", 32'(alloc_rdy), 32'(e_rdy));
    chk("count", 32'(count), 32'(q.size()));
    chk("alloc0_slot", 32'(alloc0_slot), 32'(tail_slot));
    chk("alloc1_slot", 32'(alloc1_slot), 32'((tail_slot + 1) % DEPTH));
    chk("wen0_p", 32'(wen0_p), 32'(e_w0));
    chk("wen1_p", 32'(wen1_p), 32'(e_w1));
    if (e_w0) begin
      chk("waddr0_p", 32'(waddr0_p), 32'(q[0].waddr));
      chk("wdata0_p", wdata0_p, q[0].data);
    end
    if (e_w1) begin
      chk("waddr1_p", 32'(waddr1_p), 32'(q[1].waddr));
      chk("wdata1_p", wdata1_p, q[1].data);
    end
    if (!s_rst_n) begin
      q.delete();
      tail_slot = 0;
    end else begin
      apply_fill(s_f0v, s_f0s, s_f0d);
      apply_fill(s_f1v, s_f1s, s_f1d);
      for (int k = 0; k < nret; k++) begin
        if (q[0].wen && q[0].waddr != 5'd0) model_rf[q[0].waddr] = q[0].data;
        void'(q.pop_front());
      end
      if (e_rdy && s_a0v) begin
        push_alloc(s_a0w, s_a0a);
        if (s_a1v) push_alloc(s_a1w, s_a1a);
      end
    end
  endtask

  // Complete every outstanding entry, two per cycle, then let them retire.
  task automatic drain();
    for (int c = 0; c < 24; c++) begin
      idle();
      foreach (q[i]) begin
        if (!q[i].done && !s_f0v) begin
          s_f0v = 1'b1; s_f0s = 4'(q[i].slot); s_f0d = $urandom;
        end else if (!q[i].done && !s_f1v) begin
          s_f1v = 1'b1; s_f1s = 4'(q[i].slot); s_f1d = $urandom;
        end
      end
      run_cycle();
    end
    chk("drain_empty", 32'(count), 32'd0);
  endtask

  task automatic rand_stim();
    int nd[$];
    s_rst_n = ($urandom_range(199) != 0);
    s_a0v = ($urandom_range(9) < 6); s_a0w = ($urandom_range(3) != 0);
    s_a0a = 5'($urandom_range(31));
    s_a1v = ($urandom_range(1) == 0); s_a1w = ($urandom_range(3) != 0);
    s_a1a = 5'($urandom_range(31));
    foreach (q[i]) if (!q[i].done) nd.push_back(q[i].slot);
    s_f0v = ($urandom_range(9) < 7);
    s_f1v = ($urandom_range(9) < 6);
    if (nd.size() > 0 && $urandom_range(4) != 0) s_f0s = 4'(nd[$urandom_range(nd.size() - 1)]);
    else s_f0s = 4'($urandom_range(DEPTH - 1));
    if (nd.size() > 0 && $urandom_range(4) != 0) s_f1s = 4'(nd[$urandom_range(nd.size() - 1)]);
    else s_f1s = 4'($urandom_range(DEPTH - 1));
    s_f0d = $urandom; s_f1d = $urandom;
  endtask

  initial begin
    int base;
    // Reset, then single alloc/fill/retire to x5.
    idle(); s_rst_n = 1'b0;
    run_cycle(); run_cycle();
    idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'd5;
    run_cycle();
    idle(); s_f0v = 1'b1; s_f0s = 4'd0; s_f0d = 32'hDEADBEEF;
    run_cycle();
    idle(); run_cycle(); run_cycle();

    // Pair x1,x2; younger completes first and must wait for the older.
    idle(); s_rst_n = 1'b0; run_cycle();
    idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'd1; s_a1v = 1'b1; s_a1w = 1'b1; s_a1a = 5'd2;
    run_cycle();
    idle(); s_f1v = 1'b1; s_f1s = 4'd1; s_f1d = 32'h22; run_cycle();
    idle(); run_cycle();
    idle(); s_f0v = 1'b1; s_f0s = 4'd0; s_f0d = 32'h11; run_cycle();
    idle(); run_cycle(); run_cycle();

    // Both entries of a pair write x7; the younger value must end in the regfile.
    base = tail_slot;
    idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'd7; s_a1v = 1'b1; s_a1w = 1'b1; s_a1a = 5'd7;
    run_cycle();
    idle(); s_f0v = 1'b1; s_f0s = 4'(base); s_f0d = 32'hA;
    s_f1v = 1'b1; s_f1s = 4'((base + 1) % DEPTH); s_f1d = 32'hB;
    run_cycle();
    idle(); run_cycle(); run_cycle();
    chk("rf_x7_younger_wins", dut_rf[7], 32'hB);

    // Fill to capacity; extra allocs dropped; retiring the head reopens allocation.
    for (int i = 0; i < 10; i++) begin
      idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'(i + 8);
      s_a1v = 1'b1; s_a1w = 1'b0; s_a1a = 5'(i + 9);
      run_cycle();
    end
    for (int i = 0; i < 2; i++) begin
      idle(); s_f0v = 1'b1; s_f0s = 4'(q[0].slot); s_f0d = 32'h100 + 32'(i);
      s_f1v = 1'b1; s_f1s = 4'((q[0].slot + 2) % DEPTH); s_f1d = 32'h200 + 32'(i);
      run_cycle();
      idle(); run_cycle();
    end
    drain();

    // Long single-alloc run to wrap the pointers.
    for (int i = 0; i < 40; i++) begin
      idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'($urandom_range(31));
      if (q.size() > 0) begin
        s_f0v = 1'b1; s_f0s = 4'(q[q.size() - 1].slot); s_f0d = $urandom;
      end
      run_cycle();
    end
    drain();

    // Reset mid-operation discards in-flight entries; late fills are ignored.
    idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'd3; s_a1v = 1'b1; s_a1w = 1'b1; s_a1a = 5'd4;
    run_cycle();
    base = tail_slot;
    idle(); s_a0v = 1'b1; s_a0w = 1'b1; s_a0a = 5'd6; run_cycle();
    idle(); s_f0v = 1'b1; s_f0s = 4'((base + DEPTH - 1) % DEPTH); s_f0d = 32'h55;
    s_f1v = 1'b1; s_f1s = 4'(base); s_f1d = 32'h66; run_cycle();
    idle(); s_rst_n = 1'b0; run_cycle();
    idle(); s_f0v = 1'b1; s_f0s = 4'((base + DEPTH - 2) % DEPTH); s_f0d = 32'h77;
    s_f1v = 1'b1; s_f1s = 4'(base); s_f1d = 32'h88; run_cycle();
    idle(); run_cycle(); run_cycle();

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rand_stim();
      run_cycle();
    end
    drain();
    idle(); run_cycle(); run_cycle();
    for (int r = 1; r < 32; r++) chk($sformatf("rf_x%0d", r), dut_rf[r], model_rf[r]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
